// File: rtl/seq_div_pkg.sv
// ============================================================================
// Module      : seq_div_pkg
// Description : Shared types and constants for the iterative restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_div_pkg;

    localparam int DIVIDEND_W_DEF = 8;
    localparam int DIVISOR_W_DEF  = 4;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_width(DIVIDEND_W_DEF);

    localparam logic [DIVIDEND_W_DEF-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/div_step.sv
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step (shift, trial
//               subtract, restore).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_step
    import seq_div_pkg::*;
#(
    parameter int DIVISOR_W = DIVISOR_W_DEF
) (
    input  logic [DIVISOR_W:0]   rem_in,
    input  logic                 dvd_bit,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W:0]   rem_out,
    output logic                 q_bit
);

    logic [DIVISOR_W+1:0] w_shift;
    logic [DIVISOR_W:0]   w_trial;

    assign w_shift = {rem_in, dvd_bit};
    assign q_bit   = (w_shift >= {2'b00, divisor});
    // A successful trial is always below the divisor, so the narrower
    // subtraction cannot lose significant bits.
    assign w_trial = w_shift[DIVISOR_W:0] - {1'b0, divisor};
    assign rem_out = q_bit ? w_trial : w_shift[DIVISOR_W:0];

endmodule

`default_nettype wire

// File: rtl/seq_div.sv
// ============================================================================
// Module      : seq_div
// Description : Iterative restoring unsigned divider, one quotient bit per
//               clock, start/done handshake. Optional SEQ_DIV_ZERO_FLAG_EN
//               adds the div_by_zero status output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_div
    import seq_div_pkg::*;
#(
    parameter int DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] data_a,
    input  logic [DIVISOR_W-1:0]  data_b,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
`ifdef SEQ_DIV_ZERO_FLAG_EN
    output logic                  div_by_zero,
`endif
    output logic [DIVISOR_W-1:0]  remainder
);

    localparam int C_CNT_W = cnt_width(DIVIDEND_W);

    state_t                r_state;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W:0]    r_prem;
    logic [C_CNT_W-1:0]    r_cnt;
    logic                  r_div0;

    logic [DIVISOR_W:0]    w_prem_next;
    logic                  w_qbit;
    logic [DIVIDEND_W-1:0] w_dvd_next;

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .rem_in  (r_prem),
        .dvd_bit (r_dvd[DIVIDEND_W-1]),
        .divisor (r_dvs),
        .rem_out (w_prem_next),
        .q_bit   (w_qbit)
    );

    // Dividend register doubles as the quotient: bits leave at the top
    // while quotient bits enter at the bottom.
    assign w_dvd_next = {r_dvd[DIVIDEND_W-2:0], w_qbit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_cnt       <= '0;
            r_div0      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
`ifdef SEQ_DIV_ZERO_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_dvd   <= data_a;
                        r_dvs   <= data_b;
                        r_prem  <= '0;
                        r_cnt   <= C_CNT_W'(DIVIDEND_W);
                        r_div0  <= (data_b == '0);
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (r_div0) begin
                        // Divide by zero: fixed result after a single cycle.
                        quotient  <= '1;
                        remainder <= r_dvd[DIVISOR_W-1:0];
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= DONE;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                        div_by_zero <= 1'b1;
`endif
                    end else begin
                        r_dvd  <= w_dvd_next;
                        r_prem <= w_prem_next;
                        r_cnt  <= r_cnt - C_CNT_W'(1);
                        if (r_cnt == C_CNT_W'(1)) begin
                            quotient  <= w_dvd_next;
                            remainder <= w_prem_next[DIVISOR_W-1:0];
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= DONE;
`ifdef SEQ_DIV_ZERO_FLAG_EN
                            div_by_zero <= 1'b0;
`endif
                        end
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_div.sv
// ============================================================================
// Module      : tb_seq_div
// Description : Self-checking bench for seq_div with an expected-result queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_a;
    logic [3:0] data_b;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
`ifdef SEQ_DIV_ZERO_FLAG_EN
    logic       div_by_zero;
`endif

    seq_div dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .data_a      (data_a),
        .data_b      (data_b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
`ifdef SEQ_DIV_ZERO_FLAG_EN
        .div_by_zero (div_by_zero),
`endif
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic [3:0] r;
        logic       dz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pushes the reference result (when tracked) and pulses start for one edge.
    task automatic launch(input logic [7:0] a, input logic [3:0] b, input bit track);
        exp_t e;
        if (b == 4'd0) begin
            e.q  = 8'hFF;
            e.r  = a[3:0];
            e.dz = 1'b1;
        end else begin
            e.q  = 8'(a / {4'd0, b});
            e.r  = 4'(a % {4'd0, b});
            e.dz = 1'b0;
        end
        if (track) sb.push_back(e);
        start  = 1'b1;
        data_a = a;
        data_b = b;
        tick();
        start  = 1'b0;
    endtask

    // Counts cycles until done, noting whether busy stayed high meanwhile.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 30) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_a = '0; data_b = '0;
        tick(); tick();
        n_checks++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_flags: busy/done=%b expected 00", {busy, done});
        else n_pass++;
        n_checks++;
        if ({quotient, remainder} !== 12'h000) $display("FAIL reset_data: q=%0d r=%0d expected 0/0", quotient, remainder);
        else n_pass++;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        n_checks++;
        if (div_by_zero !== 1'b0) $display("FAIL reset_dz: got %b expected 0", div_by_zero);
        else n_pass++;
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat; bit bok; exp_t e;
        launch(8'd200, 4'd7, 1'b1);
        wait_done(lat, bok);
        n_checks++;
        if (lat != 8) $display("FAIL basic_latency: got %0d expected 8", lat);
        else n_pass++;
        n_checks++;
        if (!bok || busy !== 1'b0) $display("FAIL basic_busy: held=%0d at_done=%b expected 1/0", bok, busy);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r)
            $display("FAIL basic_result: q=%0d r=%0d expected %0d/%0d", quotient, remainder, e.q, e.r);
        else n_pass++;
        tick();
        n_checks++;
        if (done !== 1'b0 || quotient !== 8'd28) $display("FAIL basic_pulse: done=%b q=%0d expected 0/28", done, quotient);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        int lat; bit bok; exp_t e;
        launch(8'd13, 4'd0, 1'b1);
        wait_done(lat, bok);
        n_checks++;
        if (lat != 1 || !bok || busy !== 1'b0)
            $display("FAIL div0_timing: lat=%0d busy_held=%0d busy=%b expected 1/1/0", lat, bok, busy);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r)
            $display("FAIL div0_result: q=%0d r=%0d expected %0d/%0d", quotient, remainder, e.q, e.r);
        else n_pass++;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        n_checks++;
        if (div_by_zero !== e.dz) $display("FAIL div0_flag: got %b expected %b", div_by_zero, e.dz);
        else n_pass++;
`endif
        tick(); tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || quotient !== 8'd255 || remainder !== 4'd13)
            $display("FAIL div0_hold: done=%b busy=%b q=%0d r=%0d expected 0/0/255/13", done, busy, quotient, remainder);
        else n_pass++;
    endtask

    task automatic test_ignore_busy();
        int lat; bit bok; exp_t e;
        launch(8'd5, 4'd9, 1'b1);
        tick(); tick();
        start = 1'b1; data_a = 8'd100; data_b = 4'd3;
        tick();
        start = 1'b0;
        wait_done(lat, bok);
        n_checks++;
        if (lat != 5 || !bok) $display("FAIL ignore_latency: got %0d busy_held=%0d expected 5/1", lat, bok);
        else n_pass++;
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r)
            $display("FAIL ignore_result: q=%0d r=%0d expected %0d/%0d", quotient, remainder, e.q, e.r);
        else n_pass++;
`ifdef SEQ_DIV_ZERO_FLAG_EN
        n_checks++;
        if (div_by_zero !== 1'b0) $display("FAIL ignore_dz_clear: got %b expected 0", div_by_zero);
        else n_pass++;
`endif
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || quotient !== 8'd0 || remainder !== 4'd5)
            $display("FAIL ignore_no_restart: busy=%b q=%0d r=%0d expected 0/0/5", busy, quotient, remainder);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat; bit bok; bit saw_done; exp_t e;
        launch(8'd255, 4'd15, 1'b1);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++;
        if (quotient !== e.q || remainder !== e.r)
            $display("FAIL full_range: q=%0d r=%0d expected %0d/%0d", quotient, remainder, e.q, e.r);
        else n_pass++;
        tick();
        launch(8'd200, 4'd7, 1'b0);
        tick(); tick(); tick();
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({busy, done, quotient, remainder} !== 14'd0)
            $display("FAIL async_reset: busy=%b done=%b q=%0d r=%0d expected all 0", busy, done, quotient, remainder);
        else n_pass++;
        tick();
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_checks++;
        if (saw_done) $display("FAIL abort_no_done: activity=1 expected 0");
        else n_pass++;
        launch(8'd100, 4'd3, 1'b1);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++;
        if (lat != 8 || quotient !== e.q || remainder !== e.r)
            $display("FAIL after_reset: lat=%0d q=%0d r=%0d expected 8/%0d/%0d", lat, quotient, remainder, e.q, e.r);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat; bit bok; exp_t e;
        launch(8'd100, 4'd3, 1'b1);
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++;
        if (lat != 8 || quotient !== e.q || remainder !== e.r)
            $display("FAIL b2b_first: lat=%0d q=%0d r=%0d expected 8/%0d/%0d", lat, quotient, remainder, e.q, e.r);
        else n_pass++;
        launch(8'd77, 4'd4, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 8'd33)
            $display("FAIL b2b_accept: busy=%b done=%b q=%0d expected 1/0/33", busy, done, quotient);
        else n_pass++;
        wait_done(lat, bok);
        e = sb.pop_front();
        n_checks++;
        if (lat != 8 || !bok || quotient !== e.q || remainder !== e.r)
            $display("FAIL b2b_second: lat=%0d q=%0d r=%0d expected 8/%0d/%0d", lat, quotient, remainder, e.q, e.r);
        else n_pass++;
        tick();
    endtask

    task automatic test_sweep();
        int lat; bit bok; exp_t e;
        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(8'(a), 4'(b), 1'b1);
                wait_done(lat, bok);
                e = sb.pop_front();
                n_checks++;
                if (lat != 8 || quotient !== e.q || remainder !== e.r)
                    $display("FAIL sweep %0d/%0d: lat=%0d q=%0d r=%0d expected 8/%0d/%0d",
                             a, b, lat, quotient, remainder, e.q, e.r);
                else n_pass++;
            end
        end
        tick();
    endtask

    task automatic test_mul_inverse();
        int lat; bit bok; exp_t e;
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(8'(a * b), 4'(b), 1'b1);
                wait_done(lat, bok);
                e = sb.pop_front();
                n_checks++;
                if (quotient !== 8'(a) || remainder !== 4'd0 || quotient !== e.q)
                    $display("FAIL mul_inverse %0d*%0d: q=%0d r=%0d expected %0d/0", a, b, quotient, remainder, a);
                else n_pass++;
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_busy();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        test_mul_inverse();
        n_checks++;
        if (sb.size() != 0) $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
